gr8ram_dram_ctrl: RTL and testbench
===================================

# gr8ram_dram_ctrl

Parametrised slinky-RAM engine for the GR8RAM card, intended to replace the hard-wired DRAM logic. It holds a 6502-visible, auto-incrementing address register and sequences page-mode-free DRAM read, write and CAS-before-RAS refresh cycles. All timing is locked to the Apple II PHI0/PHI1 cycle. Everything runs on rising C7M edges only; unlike the previous design, it has programmable stride, N CAS banks and a configurable refresh rate.

## Interface
- ADDR_W, 24: address register width. Must be a multiple of 8, range 16–24.
- RA_W, 11: DRAM multiplexed address width; row/column each RA_W bits.
- NBANK, 2: number of CAS banks, power of 2, 1–4. BANK_W = log2(NBANK).
- REF_DIV, 13: one refresh per REF_DIV PHI0 cycles, range 2–255.
- C7M in 1: 7M clock. All flops rise on this edge.
- RES in 1: asynchronous, active-high reset.
- PHI1 in 1: already-delayed PHI1.
- A in 4: 6502 A[3:0].
- nDEVSEL in 1; REGEN in 1: slot select and register enable.
- nWE in 1: 6502 R/W.
- Din in 8: Apple data bus.
- Dout out 8; DOE out 1: Apple data bus drive.
- RDin in 8: DRAM data.
- RDOE out 1: drive Din onto DRAM data.
- RA out RA_W: DRAM address.
- nRAS out 1; nCAS out NBANK; nRWE out 1: DRAM strobes.
- S out 3: cycle state, exported for ROM logic.

## Operation
- **State counter S.** It is loaded to 1 on the edge where PHI1 & ~PHI1reg & PHI0seen. Otherwise S=0 holds, S=7 holds, and any other value increments. PHI0seen sets on the first edge with PHI1=0.
- **Select decode.** Sel = ~nDEVSEL & REGEN. Register offsets:
  - 0 .. ADDR_W/8-1: address bytes, LSB first.
  - 3: data port.
  - 4: stride, reset value 1.
  - 5: ID byte, {BANK_W[3:0], RA_W[3:0]}.
  - All other offsets read 0.
- **Access latch.** On the edge with S==4, latch:
  - Acc = Sel & A==3.
  - AccWr = ~nWE.
  - Bank = Addr[2·RA_W +: BANK_W]. Address bits above 2·RA_W+BANK_W are ignored, so the memory mirrors.
- **Address mux.** Row = Addr[RA_W +: RA_W]; column = Addr[RA_W-1:0]. RA outputs the column when ASel=1, otherwise the row.
- **Read access.** Driven through registered outputs:
  - Edge S==4: nRAS←0.
  - Edge S==5: ASel←1.
  - Edge S==6: nCAS[Bank]←0.
- **Write access.** Driven through registered outputs:
  - Edge S==4: nRWE←0.
  - Edge S==5: nRAS←0.
  - Edge S==6: ASel←1.
  - Edge S==7: nCAS[Bank]←0. Because S holds at 7, this strobe is only issued once.
- **Release.** On the S→1 resync edge, nRAS, all nCAS, nRWE and ASel all return to their idle levels.
- **Refresh (CBR).** A counter advances on edge S==3 and wraps at REF_DIV-1 to 0. When the counter is 0:
  - Edge S==1: all nCAS←0.
  - Edge S==2: nRAS←0.
  - Edge S==3: nRAS and nCAS←1.
  - Refresh therefore always completes, with one state of precharge, before any access RAS.
- **Auto-increment.** If Acc was set, then on the next S→1 edge Addr←Addr+Stride, modulo 2^ADDR_W, in one cycle.
- **Register writes.** On edge S==6 when Sel & ~nWE, the addressed byte ←Din.
  - Slinky carry: when writing address byte k, if old bit7=1 and new bit7=0, bytes above k increment by 1 (full ripple) on the same edge.
  - A write to the top byte produces no carry.
- **Data bus enable.** Den is set on edge S==4 and cleared on the resync edge.
  - DOE = Den & Sel & nWE.
  - RDOE = Den & Acc & AccWr.
- **Read data.** Dout is combinational from A: the address bytes, RDin, the stride register, or the ID byte, per the offset map.

## Timing
- Reset values:
  - nRAS, nCAS, nRWE = 1.
  - DOE, RDOE, ASel, Den, Acc = 0.
  - S = 0, PHI0seen = 0, Addr = 0, Stride = 1, refresh counter = 0. Refresh is therefore due on the first valid cycle.
- RES mid-cycle: all strobes deassert immediately (asynchronously). The block then waits for PHI1 low followed by a rising edge before running any cycle.
- Read data timing: CAS is low for all of S7; RDin is valid ≤70 ns after the edge S==6.
- Stride=0: the address does not change.
- Register writes and increments never share an edge (S6 vs S1).
- With PHI1 stuck, S saturates at 7. Strobes stay asserted until the next resync or reset; this is the documented behaviour.

## Structure
- Package gr8ram_pkg holds the register offsets, the S state constants (S_IDLE, S1..S7), and the ID-byte layout.
- Sub-module gr8ram_addr_reg holds the address register, the stride register, byte writes, slinky carry and the stride add. The parent keeps the sequencer, the refresh counter and the strobes.

## Test plan
- **Reset release.** Release RES, run PHI1 cycles. Expect exactly one CBR refresh per 13 cycles, with nCAS low in S2–S3 and nRAS low in S3 only.
- **Address write.** Write 0x12, 0x34, 0x80 to offsets 2, 1, 0, then write 0x00 to offset 0. Expect a readback of 0x12/0x35/0x00.
- **Read of data port.** Set Addr=0x400123, default params.
  - Expect nCAS[1] to strobe, with RA row=0x000 and column=0x123.
  - Expect Dout=RDin.
  - Expect Addr to read back 0x400124 after the next resync.
- **Write of data port.** Set stride 0x10, Addr=0x0007F8.
  - Expect nRWE low from S5, RAS in S6, CAS in S7, RDOE high S5–S7.
  - Expect Addr=0x000808 afterwards.
- **Wrap-around.** Set Addr=0xFFFFFF with stride 1, then access the data port. Expect Addr=0x000000 and no spurious strobe.
- **Reset mid-write.** Assert RES during S6 of a write. Expect all strobes inactive within the reset propagation delay, and no increment.

Source files
------------

// File: rtl/gr8ram_pkg.sv
// GR8RAM slinky DRAM engine: shared constants.
// Cycle states, register offsets and the ID-byte layout.
`timescale 1ns/1ps
package gr8ram_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S1     = 3'd1,
    S2     = 3'd2,
    S3     = 3'd3,
    S4     = 3'd4,
    S5     = 3'd5,
    S6     = 3'd6,
    S7     = 3'd7
  } state_t;

  localparam logic [3:0] OFF_DATA   = 4'd3;
  localparam logic [3:0] OFF_STRIDE = 4'd4;
  localparam logic [3:0] OFF_ID     = 4'd5;

  function automatic logic [7:0] id_byte(
    input int bank_w,
    input int ra_w
  );
    return {4'(bank_w), 4'(ra_w)};
  endfunction

endpackage

// File: rtl/gr8ram_addr_reg.sv
// GR8RAM address and stride registers.
// Ports: clk/rst, byte write (wr_en/wr_off/wr_data), inc, addr, stride.
`timescale 1ns/1ps
module gr8ram_addr_reg
  import gr8ram_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_off,
  input  logic [7:0]        wr_data,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        stride
);

  localparam int NB = ADDR_W / 8;

  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        stride_nxt;

  always_comb begin
    addr_nxt   = addr;
    stride_nxt = stride;
    if (inc) begin
      addr_nxt = addr + ADDR_W'(stride);
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_off == 4'(k)) begin
          addr_nxt[8*k +: 8] = wr_data;
          // bit7 falling 1->0 ripples into the bytes above
          if (k < NB - 1 && addr[8*k+7] && !wr_data[7])
            addr_nxt = addr_nxt
                     + (ADDR_W'(1) << (8*k + 8));
        end
      end
      if (wr_off == OFF_STRIDE)
        stride_nxt = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr   <= '0;
      stride <= 8'd1;
    end else begin
      addr   <= addr_nxt;
      stride <= stride_nxt;
    end
  end

endmodule

// File: rtl/gr8ram_dram_ctrl.sv
// GR8RAM DRAM sequencer: PHI1-locked state counter, CBR refresh, strobes.
// Ports: C7M/RES, PHI1, 6502 bus (A,nDEVSEL,REGEN,nWE,Din,Dout,DOE), DRAM side.
`timescale 1ns/1ps
module gr8ram_dram_ctrl
  import gr8ram_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int RA_W    = 11,
  parameter int NBANK   = 2,
  parameter int REF_DIV = 13
) (
  input  logic             C7M,
  input  logic             RES,
  input  logic             PHI1,
  input  logic [3:0]       A,
  input  logic             nDEVSEL,
  input  logic             REGEN,
  input  logic             nWE,
  input  logic [7:0]       Din,
  output logic [7:0]       Dout,
  output logic             DOE,
  input  logic [7:0]       RDin,
  output logic             RDOE,
  output logic [RA_W-1:0]  RA,
  output logic             nRAS,
  output logic [NBANK-1:0] nCAS,
  output logic             nRWE,
  output logic [2:0]       S
);

  localparam int BANK_W = $clog2(NBANK);
  localparam int BW     = (BANK_W > 0) ? BANK_W : 1;
  localparam int NB     = ADDR_W / 8;
  localparam logic [7:0] ID = id_byte(BANK_W, RA_W);

  state_t            s_q, s_nxt;
  logic              phi1_q, phi0_seen, resync;
  logic [7:0]        ref_cnt;
  logic              ref_due;
  logic              sel, acc_now, wr_en, inc;
  logic              asel, den, acc, acc_wr;
  logic [BW-1:0]     bank, bank_nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        stride;

  assign resync  = PHI1 & ~phi1_q & phi0_seen;
  assign sel     = ~nDEVSEL & REGEN;
  assign acc_now = sel & (A == OFF_DATA);
  assign ref_due = (ref_cnt == 8'd0);
  assign wr_en   = (s_q == S6) & ~resync & sel & ~nWE;
  assign inc     = resync & acc;
  assign bank_nxt = (NBANK > 1) ? addr[2*RA_W +: BW] : '0;

  gr8ram_addr_reg #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk     (C7M),
    .rst     (RES),
    .wr_en   (wr_en),
    .wr_off  (A),
    .wr_data (Din),
    .inc     (inc),
    .addr    (addr),
    .stride  (stride)
  );

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      s_q       <= S_IDLE;
      phi1_q    <= 1'b0;
      phi0_seen <= 1'b0;
    end else begin
      s_q    <= s_nxt;
      phi1_q <= PHI1;
      if (!PHI1)
        phi0_seen <= 1'b1;
    end
  end

  // idle and S7 both hold until the next PHI1 rise
  always_comb begin
    s_nxt = s_q;
    if (resync)
      s_nxt = S1;
    else if (s_q != S_IDLE && s_q != S7)
      s_nxt = state_t'(s_q + 3'd1);
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES)
      ref_cnt <= '0;
    else if (s_q == S3 && !resync)
      ref_cnt <= (ref_cnt == 8'(REF_DIV - 1))
               ? 8'd0 : ref_cnt + 8'd1;
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      nRAS   <= 1'b1;
      nCAS   <= '1;
      nRWE   <= 1'b1;
      asel   <= 1'b0;
      den    <= 1'b0;
      acc    <= 1'b0;
      acc_wr <= 1'b0;
      bank   <= '0;
    end else if (resync) begin
      nRAS <= 1'b1;
      nCAS <= '1;
      nRWE <= 1'b1;
      asel <= 1'b0;
      den  <= 1'b0;
      acc  <= 1'b0;
    end else begin
      case (s_q)
        S1: if (ref_due) nCAS <= '0;
        S2: if (ref_due) nRAS <= 1'b0;
        S3: if (ref_due) begin
          nRAS <= 1'b1;
          nCAS <= '1;
        end
        S4: begin
          den    <= 1'b1;
          acc    <= acc_now;
          acc_wr <= ~nWE;
          bank   <= bank_nxt;
          if (acc_now) begin
            if (nWE) nRAS <= 1'b0;
            else     nRWE <= 1'b0;
          end
        end
        S5: if (acc) begin
          if (acc_wr) nRAS <= 1'b0;
          else        asel <= 1'b1;
        end
        S6: if (acc) begin
          if (acc_wr) asel <= 1'b1;
          else        nCAS[bank] <= 1'b0;
        end
        S7: if (acc && acc_wr) nCAS[bank] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign S    = s_q;
  assign DOE  = den & sel & nWE;
  assign RDOE = den & acc & acc_wr;
  assign RA   = asel ? addr[RA_W-1:0]
                     : addr[RA_W +: RA_W];

  always_comb begin
    Dout = '0;
    for (int k = 0; k < NB; k++)
      if (A == 4'(k)) Dout = addr[8*k +: 8];
    case (A)
      OFF_DATA:   Dout = RDin;
      OFF_STRIDE: Dout = stride;
      OFF_ID:     Dout = ID;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gr8ram_dram_ctrl.sv
// Directed bench for gr8ram_dram_ctrl.
// PHI1 is a 10-clock cycle (5 high, 5 low); edge p of a cycle has phase==p.
`timescale 1ns/1ps
module tb_gr8ram_dram_ctrl;

  localparam int P = 10;

  logic       C7M = 1'b0;
  logic       RES = 1'b1;
  logic       PHI1 = 1'b0;
  logic [3:0] A = 4'd0;
  logic       nDEVSEL = 1'b1;
  logic       REGEN = 1'b1;
  logic       nWE = 1'b1;
  logic [7:0] Din = 8'd0;
  logic [7:0] Dout;
  logic       DOE;
  logic [7:0] RDin = 8'd0;
  logic       RDOE;
  logic [10:0] RA;
  logic       nRAS;
  logic [1:0] nCAS;
  logic       nRWE;
  logic [2:0] S;

  int phase = 0;
  int total = 0;
  int bad = 0;

  gr8ram_dram_ctrl #(
    .ADDR_W (24),
    .RA_W   (11),
    .NBANK  (2),
    .REF_DIV(13)
  ) dut (
    .C7M    (C7M),
    .RES    (RES),
    .PHI1   (PHI1),
    .A      (A),
    .nDEVSEL(nDEVSEL),
    .REGEN  (REGEN),
    .nWE    (nWE),
    .Din    (Din),
    .Dout   (Dout),
    .DOE    (DOE),
    .RDin   (RDin),
    .RDOE   (RDOE),
    .RA     (RA),
    .nRAS   (nRAS),
    .nCAS   (nCAS),
    .nRWE   (nRWE),
    .S      (S)
  );

  initial forever #10 C7M = ~C7M;

  initial forever begin
    @(negedge C7M);
    phase = (phase + 1) % P;
    PHI1 = (phase < 5);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic wait_edge(input int p);
    int n;
    n = 0;
    do begin
      @(posedge C7M);
      #1;
      n++;
    end while (phase != p && n < 3*P);
    if (phase != p) begin
      total++;
      bad++;
      $display("FAIL wait_edge got phase %0d want %0d", phase, p);
    end
  endtask

  task automatic start_cycle(input logic [3:0] a,
                             input logic we_n,
                             input logic [7:0] d);
    wait_edge(0);
    A = a;
    nWE = we_n;
    Din = d;
    nDEVSEL = 1'b0;
  endtask

  task automatic end_cycle();
    wait_edge(0);
    nDEVSEL = 1'b1;
    nWE = 1'b1;
    A = 4'd0;
    Din = 8'd0;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    start_cycle(a, 1'b0, d);
    end_cycle();
  endtask

  task automatic reg_read(input logic [3:0] a,
                          output logic [7:0] d,
                          output logic doe);
    start_cycle(a, 1'b1, 8'd0);
    wait_edge(5);
    d = Dout;
    doe = DOE;
    end_cycle();
  endtask

  task automatic test_reset();
    logic got, exp;
    repeat (3) @(posedge C7M);
    #1;
    total++; if (nRAS !== 1'b1) begin bad++;
      $display("FAIL rst_nras got %b want 1", nRAS); end
    total++; if (nCAS !== 2'b11) begin bad++;
      $display("FAIL rst_ncas got %b want 11", nCAS); end
    total++; if (nRWE !== 1'b1) begin bad++;
      $display("FAIL rst_nrwe got %b want 1", nRWE); end
    total++; if (DOE !== 1'b0) begin bad++;
      $display("FAIL rst_doe got %b want 0", DOE); end
    total++; if (RDOE !== 1'b0) begin bad++;
      $display("FAIL rst_rdoe got %b want 0", RDOE); end
    total++; if (S !== 3'd0) begin bad++;
      $display("FAIL rst_s got %0d want 0", S); end
    wait_edge(7);
    RES = 1'b0;
    wait_edge(9);
    total++; if (S !== 3'd0) begin bad++;
      $display("FAIL pre_sync_s got %0d want 0", S); end
    for (int c = 0; c < 26; c++) begin
      wait_edge(1);
      got = (nCAS === 2'b00);
      exp = (c % 13 == 0);
      total++; if (got !== exp) begin bad++;
        $display("FAIL refresh_%0d got %b want %b", c, got, exp); end
      if (c == 0) begin
        total++; if (S !== 3'd2) begin bad++;
          $display("FAIL ref_s2 got %0d want 2", S); end
        total++; if (nRAS !== 1'b1) begin bad++;
          $display("FAIL ref_s2_nras got %b want 1", nRAS); end
        wait_edge(2);
        total++; if (nCAS !== 2'b00 || nRAS !== 1'b0) begin bad++;
          $display("FAIL ref_s3 got cas=%b ras=%b want 00/0", nCAS, nRAS); end
        wait_edge(3);
        total++; if (nCAS !== 2'b11 || nRAS !== 1'b1) begin bad++;
          $display("FAIL ref_s4 got cas=%b ras=%b want 11/1", nCAS, nRAS); end
      end
    end
  endtask

  task automatic test_addr_write();
    logic [3:0] offs [6] = '{4'd2, 4'd1, 4'd0, 4'd4, 4'd5, 4'd7};
    logic [7:0] exps [6] = '{8'h12, 8'h35, 8'h00, 8'h01, 8'h1B, 8'h00};
    logic [7:0] d;
    logic doe;
    reg_write(4'd2, 8'h12);
    reg_write(4'd1, 8'h34);
    reg_write(4'd0, 8'h80);
    reg_write(4'd0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      reg_read(offs[i], d, doe);
      total++; if (d !== exps[i]) begin bad++;
        $display("FAIL rd_off%0d got %h want %h", offs[i], d, exps[i]); end
      if (i == 0) begin
        total++; if (doe !== 1'b1) begin bad++;
          $display("FAIL rd_doe got %b want 1", doe); end
      end
    end
  endtask

  task automatic test_data_read();
    logic [3:0] offs [3] = '{4'd0, 4'd1, 4'd2};
    logic [7:0] exps [3] = '{8'h24, 8'h01, 8'h40};
    logic [7:0] d;
    logic doe;
    reg_write(4'd2, 8'h40);
    reg_write(4'd1, 8'h01);
    reg_write(4'd0, 8'h23);
    RDin = 8'hA5;
    start_cycle(4'd3, 1'b1, 8'd0);
    wait_edge(4);
    total++; if (nRAS !== 1'b0 || RA !== 11'h000 || nCAS !== 2'b11) begin bad++;
      $display("FAIL drd_row got ras=%b ra=%h cas=%b want 0/000/11", nRAS, RA, nCAS); end
    wait_edge(5);
    total++; if (RA !== 11'h123) begin bad++;
      $display("FAIL drd_col got %h want 123", RA); end
    wait_edge(6);
    total++; if (nCAS !== 2'b01 || nRWE !== 1'b1) begin bad++;
      $display("FAIL drd_cas got cas=%b we=%b want 01/1", nCAS, nRWE); end
    total++; if (Dout !== 8'hA5 || DOE !== 1'b1 || RDOE !== 1'b0) begin bad++;
      $display("FAIL drd_data got %h doe=%b rdoe=%b want a5/1/0", Dout, DOE, RDOE); end
    end_cycle();
    total++; if (nRAS !== 1'b1 || nCAS !== 2'b11) begin bad++;
      $display("FAIL drd_release got ras=%b cas=%b want 1/11", nRAS, nCAS); end
    RDin = 8'h00;
    for (int i = 0; i < 3; i++) begin
      reg_read(offs[i], d, doe);
      total++; if (d !== exps[i]) begin bad++;
        $display("FAIL drd_inc_b%0d got %h want %h", i, d, exps[i]); end
    end
  endtask

  task automatic test_data_write();
    logic [3:0] offs [3] = '{4'd0, 4'd1, 4'd2};
    logic [7:0] exps [3] = '{8'h08, 8'h08, 8'h00};
    logic [7:0] d;
    logic doe;
    reg_write(4'd4, 8'h10);
    reg_write(4'd2, 8'h00);
    reg_write(4'd1, 8'h07);
    reg_write(4'd0, 8'hF8);
    start_cycle(4'd3, 1'b0, 8'h5A);
    wait_edge(4);
    total++; if (nRWE !== 1'b0 || nRAS !== 1'b1) begin bad++;
      $display("FAIL dwr_s5 got we=%b ras=%b want 0/1", nRWE, nRAS); end
    total++; if (RDOE !== 1'b1 || DOE !== 1'b0) begin bad++;
      $display("FAIL dwr_oe got rdoe=%b doe=%b want 1/0", RDOE, DOE); end
    wait_edge(5);
    total++; if (nRAS !== 1'b0 || RA !== 11'h000) begin bad++;
      $display("FAIL dwr_s6 got ras=%b ra=%h want 0/000", nRAS, RA); end
    wait_edge(6);
    total++; if (RA !== 11'h7F8 || nCAS !== 2'b11) begin bad++;
      $display("FAIL dwr_col got ra=%h cas=%b want 7f8/11", RA, nCAS); end
    wait_edge(7);
    total++; if (nCAS !== 2'b10 || RDOE !== 1'b1) begin bad++;
      $display("FAIL dwr_cas got cas=%b rdoe=%b want 10/1", nCAS, RDOE); end
    end_cycle();
    total++; if (nRWE !== 1'b1 || nCAS !== 2'b11 || RDOE !== 1'b0) begin bad++;
      $display("FAIL dwr_release got we=%b cas=%b rdoe=%b want 1/11/0", nRWE, nCAS, RDOE); end
    for (int i = 0; i < 3; i++) begin
      reg_read(offs[i], d, doe);
      total++; if (d !== exps[i]) begin bad++;
        $display("FAIL dwr_inc_b%0d got %h want %h", i, d, exps[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic doe;
    reg_write(4'd4, 8'h01);
    reg_write(4'd2, 8'hFF);
    reg_write(4'd1, 8'hFF);
    reg_write(4'd0, 8'hFF);
    start_cycle(4'd3, 1'b1, 8'd0);
    end_cycle();
    wait_edge(6);
    total++; if (nCAS !== 2'b11 || nRAS !== 1'b1) begin bad++;
      $display("FAIL wrap_idle got cas=%b ras=%b want 11/1", nCAS, nRAS); end
    wait_edge(8);
    total++; if (nCAS !== 2'b11) begin bad++;
      $display("FAIL wrap_idle7 got cas=%b want 11", nCAS); end
    for (int i = 0; i < 3; i++) begin
      reg_read(4'(i), d, doe);
      total++; if (d !== 8'h00) begin bad++;
        $display("FAIL wrap_b%0d got %h want 00", i, d); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    logic doe;
    reg_write(4'd0, 8'h42);
    start_cycle(4'd3, 1'b0, 8'h77);
    wait_edge(6);
    total++; if (nRAS !== 1'b0 || nRWE !== 1'b0) begin bad++;
      $display("FAIL mid_pre got ras=%b we=%b want 0/0", nRAS, nRWE); end
    RES = 1'b1;
    nDEVSEL = 1'b1;
    nWE = 1'b1;
    A = 4'd0;
    #1;
    total++; if (nRAS !== 1'b1 || nCAS !== 2'b11 || nRWE !== 1'b1) begin bad++;
      $display("FAIL mid_strobes got ras=%b cas=%b we=%b want 1/11/1", nRAS, nCAS, nRWE); end
    total++; if (RDOE !== 1'b0 || S !== 3'd0) begin bad++;
      $display("FAIL mid_state got rdoe=%b s=%0d want 0/0", RDOE, S); end
    wait_edge(2);
    RES = 1'b0;
    wait_edge(4);
    total++; if (S !== 3'd0) begin bad++;
      $display("FAIL mid_wait_hi got %0d want 0", S); end
    wait_edge(9);
    total++; if (S !== 3'd0) begin bad++;
      $display("FAIL mid_wait_lo got %0d want 0", S); end
    wait_edge(0);
    total++; if (S !== 3'd1) begin bad++;
      $display("FAIL mid_resync got %0d want 1", S); end
    reg_read(4'd0, d, doe);
    total++; if (d !== 8'h00) begin bad++;
      $display("FAIL mid_addr got %h want 00", d); end
    reg_read(4'd4, d, doe);
    total++; if (d !== 8'h01) begin bad++;
      $display("FAIL mid_stride got %h want 01", d); end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_data_read();
    test_data_write();
    test_wrap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
